// File: rtl/ospfb_phasecomp_pingpong.sv
// Phase-compensation ping-pong stage between the polyphase FIR and the FFT.
// Each M-sample frame is buffered in one bank while the other bank is read back rotated by (k*D) mod M.
module ospfb_phasecomp_pingpong #(
  parameter int WIDTH     = 16,
  parameter int FFT_LEN   = 64,
  parameter int DEC_FAC   = 48,
  parameter int SHIFT_DIR = 0,
  localparam int AW       = $clog2(FFT_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bypass,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [AW-1:0]    m_axis_tuser,
  output logic [1:0]       state,
  output logic             err
);

  // state | meaning
  // IDLE  | no input accepted since reset
  // FILLA | writer is filling bank A
  // FILLB | writer is filling bank B
  // ERR   | frame-alignment error seen, held until reset
  typedef enum logic [1:0] {IDLE = 2'd0, FILLA = 2'd1, FILLB = 2'd2, ERR = 2'd3} state_t;

  localparam logic [AW-1:0] DINC = AW'(DEC_FAC % FFT_LEN);
  localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

  state_t           state_q, state_d;
  logic             rst_meta, rst_sync;
  logic [WIDTH-1:0] mem [2*FFT_LEN];
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    wr_ptr, rd_ptr, s_acc, s_lat, s_new, s_eff, rd_addr, s1;
  logic [1:0]       full;
  logic             wb, ib, v1, last1;
  logic             wr_fire, wr_ok, wr_last, align_err, kill, en, issue, iss_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign s_axis_tready = !full[wb] && (state_q != ERR);
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign wr_last       = (wr_ptr == LAST);
  assign align_err     = wr_fire && (s_axis_tlast != wr_last);
  assign wr_ok         = wr_fire && !align_err;
  assign kill          = align_err || (state_q == ERR);

  // rd_ptr==0 marks a read-frame start, where the shift (and bypass) is sampled
  assign en       = !m_axis_tvalid || m_axis_tready;
  assign issue    = en && !kill && full[ib];
  assign iss_last = (rd_ptr == LAST);
  assign s_new    = bypass ? '0 : s_acc;
  assign s_eff    = (rd_ptr == '0) ? s_new : s_lat;
  assign rd_addr  = (SHIFT_DIR != 0) ? (rd_ptr - s_eff) : (rd_ptr + s_eff);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    if (align_err) begin
      state_d = ERR;
    end else begin
      case (state_q)
        IDLE:    if (wr_fire) state_d = FILLA;
        FILLA:   if (wr_fire && wr_last) state_d = FILLB;
        FILLB:   if (wr_fire && wr_last) state_d = FILLA;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wb, wr_ptr}] <= s_axis_tdata;
    if (en) rdata <= mem[{ib, rd_addr}];
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q       <= IDLE;
      err           <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wb            <= 1'b0;
      ib            <= 1'b0;
      full          <= '0;
      s_acc         <= '0;
      s_lat         <= '0;
      v1            <= 1'b0;
      last1         <= 1'b0;
      s1            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      state_q <= state_d;
      if (align_err) err <= 1'b1;
      if (wr_ok) begin
        if (wr_last) begin
          wr_ptr <= '0;
          wb     <= ~wb;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      // A bank is released once its last read is issued: the tail of the frame
      // already sits in the pipeline registers, so the writer refills it bubble-free.
      for (int b = 0; b < 2; b++) begin
        if (wr_ok && wr_last && (wb == b[0])) full[b] <= 1'b1;
        else if (issue && iss_last && (ib == b[0])) full[b] <= 1'b0;
      end
      if (issue) begin
        if (rd_ptr == '0) s_lat <= s_new;
        if (iss_last) begin
          rd_ptr <= '0;
          ib     <= ~ib;
          s_acc  <= s_acc + DINC;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      if (kill) begin
        v1            <= 1'b0;
        m_axis_tvalid <= 1'b0;
      end else if (en) begin
        v1            <= issue;
        last1         <= issue && iss_last;
        s1            <= s_eff;
        m_axis_tvalid <= v1;
        m_axis_tlast  <= last1;
        m_axis_tuser  <= s1;
        m_axis_tdata  <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_ospfb_phasecomp_pingpong.sv
// Scoreboard bench for ospfb_phasecomp_pingpong (M=64, D=48, SHIFT_DIR=0).
module tb_ospfb_phasecomp_pingpong;

  localparam int M = 64;
  localparam int D = 48;

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [5:0]  user;
  } exp_t;

  logic        clk, rst_n, bypass;
  logic [15:0] s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [5:0]  m_axis_tuser;
  logic [1:0]  state;
  logic        err;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0, n_fail = 0;
  int   sacc = 0, out_cnt = 0, extra = 0, cyc = 0, first_hs = 0, last_hs = 0;
  int   rdy_mode = 0;

  ospfb_phasecomp_pingpong #(.WIDTH(16), .FFT_LEN(M), .DEC_FAC(D), .SHIFT_DIR(0)) dut (
    .clk(clk), .rst_n(rst_n), .bypass(bypass),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .state(state), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 1) == 1);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // handshakes seen at the negedge complete on the following posedge
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        extra++;
        check_eq("extra_beat", extra, 0);
      end else begin
        e = q.pop_front();
        check_eq("tdata", {16'd0, m_axis_tdata}, {16'd0, e.d});
        check_eq("tlast", {31'd0, m_axis_tlast}, {31'd0, e.last});
        check_eq("tuser", {26'd0, m_axis_tuser}, {26'd0, e.user});
      end
      if (out_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      out_cnt++;
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    acc = 0;
    while (!acc && guard < 3000) begin
      s_axis_tvalid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) check_eq("send_timeout", {31'd0, s_axis_tready}, 32'd1);
  endtask

  task automatic send_frame(input int fid, input bit byp, input bit rnd);
    int s;
    exp_t x;
    s = byp ? 0 : sacc;
    sacc = (sacc + D) % M;
    for (int n = 0; n < M; n++) begin
      x.d    = {fid[7:0], 8'((n + s) % M)};
      x.last = (n == M - 1);
      x.user = 6'(s);
      q.push_back(x);
    end
    for (int i = 0; i < M; i++) send_beat({fid[7:0], 8'(i)}, (i == M - 1), rnd);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain", q.size(), 0);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("out_cnt_reach", {31'd0, out_cnt >= n}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    sacc = 0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bypass = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    do_reset();
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check_eq("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check_eq("rst_tuser", {26'd0, m_axis_tuser}, 32'd0);

    // five back-to-back frames: tuser 0,48,32,16,0 and no output bubbles
    for (int f = 0; f < 5; f++) send_frame(f, 1'b0, 1'b0);
    wait_drain();
    check_eq("no_bubbles", last_hs - first_hs, 5 * M - 1);
    check_eq("state_after_5", {30'd0, state}, 32'd2);

    // bypass for two frames, accumulator keeps advancing
    do_reset();
    bypass = 1'b1;
    send_frame(10, 1'b1, 1'b0);
    send_frame(11, 1'b1, 1'b0);
    wait_drain();
    bypass = 1'b0;
    send_frame(12, 1'b0, 1'b0);
    wait_drain();

    // output stall of 200 cycles after 10 beats
    do_reset();
    fork
      for (int f = 20; f < 24; f++) send_frame(f, 1'b0, 1'b0);
      begin
        wait_out(10);
        rdy_mode = 2;
        repeat (200) @(posedge clk);
        #1;
        check_eq("stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
        check_eq("stall_m_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        rdy_mode = 0;
      end
    join
    wait_drain();

    // misplaced tlast on beat 30 while a frame is streaming out
    do_reset();
    send_frame(30, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) send_beat({8'd31, 8'(i)}, 1'b0, 1'b0);
    check_eq("pre_err_m_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    send_beat({8'd31, 8'd30}, 1'b1, 1'b0);
    q.delete();
    check_eq("err_flag", {31'd0, err}, 32'd1);
    check_eq("err_state", {30'd0, state}, 32'd3);
    check_eq("err_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check_eq("err_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("err_hold_state", {30'd0, state}, 32'd3);
    check_eq("err_hold_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    do_reset();
    check_eq("err_clr_state", {30'd0, state}, 32'd0);
    check_eq("err_clr_err", {31'd0, err}, 32'd0);

    // reset in the middle of an output frame
    send_frame(40, 1'b0, 1'b0);
    send_frame(41, 1'b0, 1'b0);
    wait_out(M + 20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check_eq("mid_rst_tuser", {26'd0, m_axis_tuser}, 32'd0);
    check_eq("mid_rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check_eq("mid_rst_state", {30'd0, state}, 32'd0);
    do_reset();
    send_frame(42, 1'b0, 1'b0);
    wait_drain();

    // random valid/ready over 20 frames
    do_reset();
    rdy_mode = 1;
    for (int f = 50; f < 70; f++) send_frame(f, 1'b0, 1'b1);
    wait_drain();
    rdy_mode = 0;
    check_eq("no_extra_beats", extra, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ospfb_phasecomp_pingpong.md
Name: ospfb_phasecomp_pingpong

Overview:
Parametrised phase-compensation stage of the oversampled PFB. It sits between the polyphase FIR (PTAPS PEs) and the FFT. Each M-sample FIR output frame is written into one bank of a ping-pong buffer while the other bank is read out circularly rotated by the frame's phase offset (k*D) mod M. This generalises the fixed FILLA/FILLB scheme with:
- runtime bypass
- full AXI-stream backpressure
- IDLE and sticky ERR states
- frame-alignment checking

Parameters:
WIDTH, 16, sample word width (tdata bits)
FFT_LEN, 64, M: frame length / polyphase branches, power of 2, >= 4
DEC_FAC, 48, D: decimation factor, 0 < D <= M
SHIFT_DIR, 0, 0: out[n]=buf[(n+s) mod M]; 1: out[n]=buf[(n-s) mod M]
AW, $clog2(FFT_LEN), address/shift width (derived, not overridable)

Ports:
clk  in  1  DSP clock
rst_n  in  1  asynchronous active-low reset
bypass  in  1  1 = shift forced to 0; sampled only at read-frame start
s_axis_tdata  in  WIDTH  FIR output sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  asserted on sample M-1 of each frame
m_axis_tdata  out  WIDTH  rotated sample to FFT
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  FFT ready
m_axis_tlast  out  1  asserted on output sample M-1
m_axis_tuser  out  AW  shift s applied to the current output frame
state  out  2  IDLE=0, FILLA=1, FILLB=2, ERR=3
err  out  1  sticky frame-alignment error

Behaviour:
- Reset (async assert, sync deassert internally) values:
  - all outputs 0 except s_axis_tready=1 and state=IDLE
  - wr_ptr=0, rd_ptr=0, wb=A, rb=A, full[A]=full[B]=0, k-shift accumulator s_acc=0
- States:
  - IDLE -> FILLA on the first accepted input beat.
  - FILLA <-> FILLB on acceptance of beat M-1 of a frame.
  - Any state -> ERR on an alignment error. ERR is left only by reset.
- Write side:
  - s_axis_tready = !full[wb] && state!=ERR.
  - Accepted beat writes mem[wb][wr_ptr] and increments wr_ptr.
  - At wr_ptr==M-1: sets full[wb], toggles wb, wr_ptr wraps to 0.
- Alignment error: an accepted beat with tlast != (wr_ptr==M-1) sets err=1 and enters ERR. The beat is not written.
- ERR effects: s_axis_tready=0 and m_axis_tvalid=0 from the next cycle. The output frame in flight is abandoned.
- Read side:
  - When full[rb] and no frame is active, a read frame starts.
  - On start, latch s = bypass ? 0 : s_acc; m_axis_tuser=s for the whole frame.
  - Read address = (rd_ptr ± s) mod M; the wrap is implicit in AW-bit arithmetic.
  - Synchronous RAM read plus output register gives 2-cycle latency from frame start to the first m_axis_tvalid.
  - Pipeline stalls cleanly under m_axis_tready=0: data and tvalid hold, no beat is dropped or duplicated. A skid or hold register is permitted.
- Frame end: on the handshake of output sample M-1 (m_axis_tlast=1):
  - clear full[rb], toggle rb
  - s_acc <= (s_acc + D) mod M, regardless of bypass
- Steady state: after the first frame is written, the first output beat is valid 2 cycles after acceptance of beat M-1.
- Simultaneous write and read: a write completing into bank X and a read completing from bank Y in the same cycle are both honoured. If the write side is blocked on full[wb] and the read frame ends that cycle, tready rises the next cycle.
- Throughput: 1 sample/cycle sustained with tready=1 both sides; zero bubbles between consecutive output frames.
- Reset mid-frame: all partial frames are discarded and s_acc returns to 0.

Test Plan:
- M=64, D=48, ramp input 0..63 per frame, 5 frames, m_tready=1 -> tuser sequence 0,48,32,16,0; frame 2 out[0]=48, out[16]=0 (SHIFT_DIR=0); continuous output with tlast every 64 beats.
- bypass=1 for frames 1-2 then 0 -> frames 1-2 tuser=0 with identity order; frame 3 tuser=32 (s_acc advanced during bypass).
- m_tready held 0 after 10 output beats for 200 cycles -> s_tready drops after 2 more input frames are buffered; no data lost; order and values resume exactly.
- s_tlast asserted on beat 30 -> err=1, state=ERR, s_tready=0 and m_tvalid=0 next cycle; held until rst_n pulse, then state=IDLE and err=0.
- rst_n pulsed low mid-output-frame -> outputs at reset values immediately; next frame tuser=0.
- Random tvalid/tready toggling (50%) over 20 frames -> output matches golden rotate((k*48) mod 64) model bit-exactly.
